// File: rtl/hilo_div_ctrl_pkg.sv
// Shared widths, step count, state encoding and operand helper for the HI/LO divide controller.
package hilo_div_ctrl_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned DATA_W         = REG_DATA_WIDTH;
  localparam int unsigned DIV_STEPS      = 32;
  localparam int unsigned CNT_W          = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_BUSY = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Magnitude of an operand; only signed operations treat the MSB as a sign.
  function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v, input logic sgn);
    abs_op = (sgn && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Issue/result bundle between the EX stage and the divide controller.
interface hilo_div_ctrl_if;
  import hilo_div_ctrl_pkg::*;

  logic              start_i;
  logic              signed_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic              annul_i;
  logic              stall_req_o;
  logic              ready_o;
  logic              hilo_wen_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  stall_req_o, ready_o, hilo_wen_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output stall_req_o, ready_o, hilo_wen_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_div_ctrl_div_step.sv
// One restoring shift-subtract step on {rem,quo}; purely combinational.
module hilo_div_ctrl_div_step
  import hilo_div_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;
  logic              ge;

  // Shifted remainder needs one extra bit so large divisors compare correctly.
  always_comb begin
    rem_sh = {rem_i, quo_i[DATA_W-1]};
    ge     = (rem_sh >= {1'b0, divisor_i});
    diff   = rem_sh[DATA_W-1:0] - divisor_i;
    rem_o  = ge ? diff : rem_sh[DATA_W-1:0];
    quo_o  = {quo_i[DATA_W-2:0], ge};
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU controller: stalls the pipe, runs 32 restoring steps,
// applies sign fix-up and presents quotient on LO / remainder on HI.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  hilo_div_ctrl_if.slave  bus
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              first_q, first_d;
  logic              stall_c;
  logic              ready_c;
  logic [DATA_W-1:0] step_rem, step_quo;

  hilo_div_ctrl_div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      first_q   <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    first_d   = 1'b0;
    stall_c   = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start_i) begin
          stall_c = 1'b1;
          if (bus.opdata2_i == '0) begin
            hi_d    = bus.opdata1_i;
            lo_d    = '1;
            state_d = DIV_ZERO;
          end else begin
            rem_d     = '0;
            quo_d     = abs_op(bus.opdata1_i, bus.signed_i);
            dvs_d     = abs_op(bus.opdata2_i, bus.signed_i);
            neg_quo_d = bus.signed_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            neg_rem_d = bus.signed_i & bus.opdata1_i[DATA_W-1];
            cnt_d     = '0;
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_ZERO: begin
        stall_c = 1'b1;
        first_d = 1'b1;
        state_d = DIV_DONE;
      end
      DIV_BUSY: begin
        stall_c = 1'b1;
        rem_d   = step_rem;
        quo_d   = step_quo;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last step: fold the sign fix-up into the result registers.
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          lo_d    = neg_quo_q ? DATA_W'(-step_quo) : step_quo;
          hi_d    = neg_rem_q ? DATA_W'(-step_rem) : step_rem;
          first_d = 1'b1;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (!bus.start_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    // A flush discards whatever is in flight.
    if (bus.annul_i) begin
      state_d = DIV_IDLE;
      first_d = 1'b0;
      stall_c = 1'b0;
    end
  end

  assign ready_c         = (state_q == DIV_DONE) && !bus.annul_i;
  assign bus.stall_req_o = stall_c;
  assign bus.ready_o     = ready_c;
  assign bus.hilo_wen_o  = ready_c && first_q;
  assign bus.hi_o        = ready_c ? hi_q : '0;
  assign bus.lo_o        = ready_c ? lo_q : '0;

endmodule
